fc_argmax: RTL

FC_ARGMAX -- requirements
Module: fc_argmax

---
 rtl/fc_argmax.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/fc_argmax.sv
// Argmax over NUM_CLASSES signed fc scores streamed in class order; emits the winning index.
// Define FC_ARGMAX_SCORE_OUT_EN to add the out_score port carrying the winning score.
module fc_argmax #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W      = 20,
  parameter int IDX_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_class
`ifdef FC_ARGMAX_SCORE_OUT_EN
  ,
  output logic signed [DATA_W-1:0] out_score
`endif
);

  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CLASSES - 1);

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_DONE    = 1'b1
  } state_t;

  state_t                    state_r, state_nxt_s;
  logic [IDX_W-1:0]          cnt_r, cnt_nxt_s;
  logic signed [DATA_W-1:0]  max_r, max_nxt_s;
  logic [IDX_W-1:0]          idx_r, idx_nxt_s;
  logic [IDX_W-1:0]          class_r, class_nxt_s;
  logic                      in_ready_r, in_ready_nxt_s;
  logic                      out_valid_r, out_valid_nxt_s;
  logic                      accept_s;
  logic                      take_s;
  logic signed [DATA_W-1:0]  cand_max_s;
  logic [IDX_W-1:0]          cand_idx_s;
`ifdef FC_ARGMAX_SCORE_OUT_EN
  logic signed [DATA_W-1:0]  score_r, score_nxt_s;
`endif

  assign accept_s = in_valid & in_ready_r;

  // Running-max candidate: class 0 always loads, later classes only on a strictly greater score
  always_comb begin
    take_s     = 1'b0;
    cand_max_s = max_r;
    cand_idx_s = idx_r;
    if (cnt_r == IDX_ZERO) begin
      take_s = 1'b1;
    end else begin
      take_s = ($signed(in_data) > max_r);
    end
    if (take_s) begin
      cand_max_s = $signed(in_data);
      cand_idx_s = cnt_r;
    end else begin
      cand_max_s = max_r;
      cand_idx_s = idx_r;
    end
  end

  // Next-state, counter, running max and result capture; flush overrides everything
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    max_nxt_s   = max_r;
    idx_nxt_s   = idx_r;
    class_nxt_s = class_r;
`ifdef FC_ARGMAX_SCORE_OUT_EN
    score_nxt_s = score_r;
`endif
    if (flush) begin
      state_nxt_s = ST_COLLECT;
      cnt_nxt_s   = IDX_ZERO;
    end else begin
      case (state_r)
        ST_COLLECT: begin
          if (accept_s) begin
            max_nxt_s = cand_max_s;
            idx_nxt_s = cand_idx_s;
            if (cnt_r == IDX_LAST) begin
              cnt_nxt_s   = IDX_ZERO;
              state_nxt_s = ST_DONE;
              class_nxt_s = cand_idx_s;
`ifdef FC_ARGMAX_SCORE_OUT_EN
              score_nxt_s = cand_max_s;
`endif
            end else begin
              cnt_nxt_s = cnt_r + IDX_ONE;
            end
          end else begin
            state_nxt_s = ST_COLLECT;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_nxt_s = ST_COLLECT;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end
        default: begin
          state_nxt_s = ST_COLLECT;
          cnt_nxt_s   = IDX_ZERO;
        end
      endcase
    end
  end

  // Handshake flags are registered copies of the next state so the ports come straight from flops
  always_comb begin
    in_ready_nxt_s  = 1'b1;
    out_valid_nxt_s = 1'b0;
    if (state_nxt_s == ST_DONE) begin
      in_ready_nxt_s  = 1'b0;
      out_valid_nxt_s = 1'b1;
    end else begin
      in_ready_nxt_s  = 1'b1;
      out_valid_nxt_s = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_COLLECT;
      cnt_r       <= IDX_ZERO;
      max_r       <= {DATA_W{1'b0}};
      idx_r       <= IDX_ZERO;
      class_r     <= IDX_ZERO;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
`ifdef FC_ARGMAX_SCORE_OUT_EN
      score_r     <= {DATA_W{1'b0}};
`endif
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      max_r       <= max_nxt_s;
      idx_r       <= idx_nxt_s;
      class_r     <= class_nxt_s;
      in_ready_r  <= in_ready_nxt_s;
      out_valid_r <= out_valid_nxt_s;
`ifdef FC_ARGMAX_SCORE_OUT_EN
      score_r     <= score_nxt_s;
`endif
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_class = class_r;
`ifdef FC_ARGMAX_SCORE_OUT_EN
  assign out_score = score_r;
`endif

endmodule
